zxb_mem_arbiter: RTL and testbench

Shares one external 8-bit async SRAM between two requesters: the ZX bus decoder (mem_req/mem_stb handshake) and a host/MCU port. Sequences SRAM address, data direction and strobes with programmable wait states. Returns read data and a one-cycle completion strobe to whichever requester was granted. ZX side has priority, bounded by a host starvation guard.

---
 rtl/zxb_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_zxb_mem_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zxb_mem_arbiter.sv
// zxb_mem_arbiter: shares one external 8-bit async SRAM between the ZX bus
// decoder and a host port. ZX has priority; a starvation counter guarantees
// the host a slot after STARVE_MAX consecutive ZX grants.
//
// state  | meaning
// IDLE   | no access in flight, arbitrating each cycle
// SETUP  | address (and write data) presented, strobes high
// ACCESS | oe_n or we_n low for WS cycles, last edge captures read data
// HOLD   | strobes high, bus held, completion strobe to the granted side
// DONE   | data bus released, wait for the granted side to drop its req
module zxb_mem_arbiter #(
    parameter int AW         = 19,
    parameter int WS         = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          zx_req,
    input  logic          zx_rnw,
    input  logic [15:0]   zx_addr,
    input  logic [AW-17:0] zx_page,
    input  logic [7:0]    zx_wdata,
    output logic [7:0]    zx_rdata,
    output logic          zx_stb,
    input  logic          host_req,
    input  logic          host_rnw,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          host_ack,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_dout,
    input  logic [7:0]    sram_din,
    output logic          sram_dir,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          busy,
    output logic          gnt_host
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int WSW = (WS > 1) ? $clog2(WS) : 1;
    localparam int STW = $clog2(STARVE_MAX + 1);
    localparam logic [WSW-1:0] WS_LAST    = WSW'(WS - 1);
    localparam logic [STW-1:0] STARVE_TOP = STW'(STARVE_MAX);

    logic [2:0]     state_q, state_d;
    logic [WSW-1:0] ws_q, ws_d;
    logic [STW-1:0] starve_q, starve_d;
    logic           rnw_q, rnw_d;
    logic           gnt_q, gnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [7:0]     dout_q, dout_d;
    logic           dir_q, dir_d;
    logic           oe_n_q, oe_n_d;
    logic           we_n_q, we_n_d;
    logic           zx_stb_q, zx_stb_d;
    logic           host_ack_q, host_ack_d;
    logic [7:0]     zx_rdata_q, zx_rdata_d;
    logic [7:0]     host_rdata_q, host_rdata_d;
    logic           busy_q, busy_d;

    // Next-state and next-output computation; every output is a register
    // loaded from its _d value so the SRAM pins are glitch-free.
    always_comb begin
        state_d      = state_q;
        ws_d         = ws_q;
        starve_d     = host_req ? starve_q : '0;
        rnw_d        = rnw_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        dir_d        = dir_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        zx_stb_d     = 1'b0;
        host_ack_d   = 1'b0;
        zx_rdata_d   = zx_rdata_q;
        host_rdata_d = host_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (host_req && (!zx_req || starve_q == STARVE_TOP)) begin
                    state_d  = S_SETUP;
                    gnt_d    = 1'b1;
                    rnw_d    = host_rnw;
                    addr_d   = host_addr;
                    dout_d   = host_wdata;
                    dir_d    = !host_rnw;
                    starve_d = '0;
                end else if (zx_req) begin
                    state_d  = S_SETUP;
                    gnt_d    = 1'b0;
                    rnw_d    = zx_rnw;
                    addr_d   = {zx_page, zx_addr};
                    dout_d   = zx_wdata;
                    dir_d    = !zx_rnw;
                    if (host_req && starve_q != STARVE_TOP)
                        starve_d = starve_q + STW'(1);
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                ws_d    = '0;
                oe_n_d  = !rnw_q;
                we_n_d  = rnw_q;
            end
            S_ACCESS: begin
                if (ws_q == WS_LAST) begin
                    state_d = S_HOLD;
                    ws_d    = '0;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (gnt_q) begin
                        host_ack_d = 1'b1;
                        if (rnw_q)
                            host_rdata_d = sram_din;
                    end else begin
                        zx_stb_d = 1'b1;
                        if (rnw_q)
                            zx_rdata_d = sram_din;
                    end
                end else begin
                    ws_d = ws_q + WSW'(1);
                end
            end
            S_HOLD: begin
                state_d = S_DONE;
                dir_d   = 1'b0;
            end
            S_DONE: begin
                // A still-held request is never re-granted; it must drop first.
                if (gnt_q ? !host_req : !zx_req)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dir_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset; reset abandons any
    // access in flight without issuing a completion strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ws_q         <= '0;
            starve_q     <= '0;
            rnw_q        <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            dir_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            zx_stb_q     <= 1'b0;
            host_ack_q   <= 1'b0;
            zx_rdata_q   <= '0;
            host_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ws_q         <= ws_d;
            starve_q     <= starve_d;
            rnw_q        <= rnw_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            dir_q        <= dir_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            zx_stb_q     <= zx_stb_d;
            host_ack_q   <= host_ack_d;
            zx_rdata_q   <= zx_rdata_d;
            host_rdata_q <= host_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_dout  = dout_q;
    assign sram_dir   = dir_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign zx_stb     = zx_stb_q;
    assign host_ack   = host_ack_q;
    assign zx_rdata   = zx_rdata_q;
    assign host_rdata = host_rdata_q;
    assign busy       = busy_q;
    assign gnt_host   = gnt_q;

endmodule

// File: tb/tb_zxb_mem_arbiter.sv
// Testbench for zxb_mem_arbiter (AW=19, WS=2, STARVE_MAX=4). A monitor pops
// the expected-transaction queue on every zx_stb/host_ack and checks the
// requester, address, data and strobe-low cycle counts.
module tb_zxb_mem_arbiter;

    localparam int AW = 19;
    localparam int WS = 2;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          zx_req = 1'b0, zx_rnw = 1'b1;
    logic [15:0]   zx_addr = '0;
    logic [2:0]    zx_page = '0;
    logic [7:0]    zx_wdata = '0;
    logic [7:0]    zx_rdata;
    logic          zx_stb;
    logic          host_req = 1'b0, host_rnw = 1'b1;
    logic [AW-1:0] host_addr = '0;
    logic [7:0]    host_wdata = '0;
    logic [7:0]    host_rdata;
    logic          host_ack;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dout;
    logic [7:0]    sram_din;
    logic          sram_dir, sram_oe_n, sram_we_n, busy, gnt_host;

    zxb_mem_arbiter #(.AW(AW), .WS(WS), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .zx_req(zx_req), .zx_rnw(zx_rnw), .zx_addr(zx_addr), .zx_page(zx_page),
        .zx_wdata(zx_wdata), .zx_rdata(zx_rdata), .zx_stb(zx_stb),
        .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_dir(sram_dir), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .busy(busy), .gnt_host(gnt_host)
    );

    always #5 clk = ~clk;

    // SRAM model: drives data only while oe_n is low, value derived from address.
    assign sram_din = sram_oe_n ? 8'h00 : (sram_addr[7:0] ^ 8'h91);

    typedef struct {
        bit            is_host;
        bit            rnw;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   n_oe = 0;
    int   n_we = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                n_oe = 0;
                n_we = 0;
            end else begin
                if (!sram_oe_n) n_oe++;
                if (!sram_we_n) n_we++;
                if (zx_stb || host_ack) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: zx_stb=%b host_ack=%b with nothing expected", zx_stb, host_ack);
                    end else begin
                        mon_e = sb.pop_front();
                        total++;
                        if ({zx_stb, host_ack} !== {!mon_e.is_host, mon_e.is_host}) begin
                            bad++;
                            $display("FAIL sb_who: zx_stb/host_ack=%b%b expected %b%b", zx_stb, host_ack, !mon_e.is_host, mon_e.is_host);
                        end
                        total++;
                        if (sram_addr !== mon_e.addr) begin
                            bad++;
                            $display("FAIL sb_addr: got %h expected %h", sram_addr, mon_e.addr);
                        end
                        total++;
                        if (mon_e.rnw) begin
                            if ((mon_e.is_host ? host_rdata : zx_rdata) !== mon_e.data) begin
                                bad++;
                                $display("FAIL sb_rdata: got %h expected %h", mon_e.is_host ? host_rdata : zx_rdata, mon_e.data);
                            end
                        end else if (sram_dout !== mon_e.data) begin
                            bad++;
                            $display("FAIL sb_wdata: got %h expected %h", sram_dout, mon_e.data);
                        end
                        total++;
                        if ({n_oe, n_we} !== (mon_e.rnw ? {WS, 0} : {0, WS})) begin
                            bad++;
                            $display("FAIL sb_strobes: oe_low=%0d we_low=%0d expected rnw=%0d with %0d cycles", n_oe, n_we, mon_e.rnw, WS);
                        end
                    end
                    n_oe = 0;
                    n_we = 0;
                end
            end
        end
    end

    task automatic wait_zx(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (zx_stb === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_host(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (host_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        total++;
        if ({sram_oe_n, sram_we_n, sram_dir, zx_stb, host_ack, busy, gnt_host} !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_ctrl: oe,we,dir,stb,ack,busy,gnt=%b expected 1100000",
                     {sram_oe_n, sram_we_n, sram_dir, zx_stb, host_ack, busy, gnt_host});
        end
        total++;
        if ({sram_addr, sram_dout, zx_rdata, host_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%h dout=%h zx_rdata=%h host_rdata=%h expected all zero",
                     sram_addr, sram_dout, zx_rdata, host_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zx_read();
        zx_rnw = 1'b1; zx_page = 3'b101; zx_addr = 16'h1234;
        sb.push_back('{is_host: 1'b0, rnw: 1'b1, addr: 19'h51234, data: 8'hA5});
        zx_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) begin
                total++;
                if (sram_we_n !== 1'b1) begin
                    bad++;
                    $display("FAIL zxrd_we_high: cycle %0d we_n=%b expected 1", c, sram_we_n);
                end
            end
            if (c == 1) begin
                total++;
                if ({sram_addr, sram_oe_n, sram_dir, busy} !== {19'h51234, 1'b1, 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL zxrd_setup: addr=%h oe=%b dir=%b busy=%b expected 51234 1 0 1",
                             sram_addr, sram_oe_n, sram_dir, busy);
                end
            end
            if (c == 2 || c == 3) begin
                total++;
                if (sram_oe_n !== 1'b0) begin
                    bad++;
                    $display("FAIL zxrd_oe_low: cycle %0d oe_n=%b expected 0", c, sram_oe_n);
                end
            end
            if (c == 4) begin
                total++;
                if ({zx_stb, sram_oe_n, zx_rdata} !== {1'b1, 1'b1, 8'hA5}) begin
                    bad++;
                    $display("FAIL zxrd_stb: stb=%b oe=%b rdata=%h expected 1 1 a5", zx_stb, sram_oe_n, zx_rdata);
                end
                zx_req = 1'b0;
            end
            if (c == 6) begin
                total++;
                if ({busy, zx_stb} !== 2'b00) begin
                    bad++;
                    $display("FAIL zxrd_idle: busy=%b stb=%b expected 0 0", busy, zx_stb);
                end
            end
        end
    endtask

    task automatic test_host_write();
        int acks = 0;
        host_rnw = 1'b0; host_addr = 19'h7FFFF; host_wdata = 8'h3C;
        sb.push_back('{is_host: 1'b1, rnw: 1'b0, addr: 19'h7FFFF, data: 8'h3C});
        host_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (host_ack === 1'b1) acks++;
            total++;
            if (zx_stb !== 1'b0) begin
                bad++;
                $display("FAIL hwr_zx_quiet: cycle %0d zx_stb=%b expected 0", c, zx_stb);
            end
            if (c <= 4) begin
                total++;
                if ({sram_dir, sram_dout, sram_oe_n} !== {1'b1, 8'h3C, 1'b1}) begin
                    bad++;
                    $display("FAIL hwr_drive: cycle %0d dir=%b dout=%h oe=%b expected 1 3c 1", c, sram_dir, sram_dout, sram_oe_n);
                end
                total++;
                if (sram_we_n !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) begin
                    bad++;
                    $display("FAIL hwr_we: cycle %0d we_n=%b expected %b", c, sram_we_n, (c == 2 || c == 3) ? 1'b0 : 1'b1);
                end
            end
            if (c == 4) begin
                total++;
                if ({host_ack, gnt_host} !== 2'b11) begin
                    bad++;
                    $display("FAIL hwr_ack: ack=%b gnt_host=%b expected 1 1", host_ack, gnt_host);
                end
                host_req = 1'b0;
            end
            if (c == 5) begin
                total++;
                if ({sram_dir, host_ack} !== 2'b00) begin
                    bad++;
                    $display("FAIL hwr_release: dir=%b ack=%b expected 0 0", sram_dir, host_ack);
                end
            end
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL hwr_ack_count: got %0d expected 1", acks);
        end
    endtask

    task automatic test_simultaneous();
        int lat;
        zx_rnw = 1'b1; zx_page = 3'b010; zx_addr = 16'h00C3;
        host_rnw = 1'b1; host_addr = 19'h20056;
        sb.push_back('{is_host: 1'b0, rnw: 1'b1, addr: 19'h200C3, data: 8'h52});
        sb.push_back('{is_host: 1'b1, rnw: 1'b1, addr: 19'h20056, data: 8'hC7});
        zx_req = 1'b1;
        host_req = 1'b1;
        wait_zx(lat);
        total++;
        if ({lat, gnt_host} !== {WS + 2, 1'b0}) begin
            bad++;
            $display("FAIL sim_zx_first: latency=%0d gnt_host=%b expected %0d 0", lat, gnt_host, WS + 2);
        end
        zx_req = 1'b0;
        wait_host(lat);
        total++;
        if ({lat, gnt_host} !== {WS + 4, 1'b1}) begin
            bad++;
            $display("FAIL sim_host_next: cycles after zx_stb=%0d gnt_host=%b expected %0d 1", lat, gnt_host, WS + 4);
        end
        total++;
        if ({host_rdata, zx_rdata} !== {8'hC7, 8'h52}) begin
            bad++;
            $display("FAIL sim_rdata: host=%h zx=%h expected c7 52", host_rdata, zx_rdata);
        end
        host_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_starvation();
        string ord = "";
        int    relaunch = 0;
        int    nzx = 0;
        int    done = 0;
        zx_rnw = 1'b0; zx_page = 3'b000;
        host_rnw = 1'b1; host_addr = 19'h00077;
        for (int i = 0; i < 4; i++)
            sb.push_back('{is_host: 1'b0, rnw: 1'b0, addr: AW'(16'h0010 + i), data: 8'h40 + 8'(i)});
        sb.push_back('{is_host: 1'b1, rnw: 1'b1, addr: 19'h00077, data: 8'hE6});
        sb.push_back('{is_host: 1'b0, rnw: 1'b0, addr: 19'h00014, data: 8'h44});
        zx_addr = 16'h0010; zx_wdata = 8'h40;
        zx_req = 1'b1;
        host_req = 1'b1;
        for (int c = 0; c < 120 && done < 6; c++) begin
            tick();
            if (relaunch > 0) begin
                relaunch--;
                if (relaunch == 0) begin
                    zx_addr = 16'h0010 + 16'(nzx);
                    zx_wdata = 8'h40 + 8'(nzx);
                    zx_req = 1'b1;
                end
            end
            if (zx_stb === 1'b1) begin
                done++;
                nzx++;
                ord = {ord, "Z"};
                zx_req = 1'b0;
                if (nzx < 5) relaunch = 2;
                if (nzx == 4) begin
                    total++;
                    if (dut.starve_q !== 3'(SM)) begin
                        bad++;
                        $display("FAIL starve_full: starve_cnt=%0d expected %0d", dut.starve_q, SM);
                    end
                end
            end
            if (host_ack === 1'b1) begin
                done++;
                ord = {ord, "H"};
                host_req = 1'b0;
                total++;
                if (dut.starve_q !== 3'd0) begin
                    bad++;
                    $display("FAIL starve_clear: starve_cnt=%0d expected 0", dut.starve_q);
                end
            end
        end
        total++;
        if (ord != "ZZZZHZ") begin
            bad++;
            $display("FAIL starve_order: got %s expected ZZZZHZ", ord);
        end
        tick(); tick();
    endtask

    task automatic test_host_hold();
        int lat;
        host_rnw = 1'b0; host_addr = 19'h12345; host_wdata = 8'h69;
        sb.push_back('{is_host: 1'b1, rnw: 1'b0, addr: 19'h12345, data: 8'h69});
        host_req = 1'b1;
        wait_host(lat);
        total++;
        if (lat != WS + 2) begin
            bad++;
            $display("FAIL hold_latency: got %0d expected %0d", lat, WS + 2);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if ({busy, sram_we_n, sram_oe_n, sram_dir, host_ack} !== 5'b11100) begin
                bad++;
                $display("FAIL hold_done: cycle %0d busy,we,oe,dir,ack=%b expected 11100", c,
                         {busy, sram_we_n, sram_oe_n, sram_dir, host_ack});
            end
            if (c == 3) host_req = 1'b0;
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if ({busy, sram_we_n, host_ack} !== 3'b010) begin
                bad++;
                $display("FAIL hold_release: cycle %0d busy,we,ack=%b expected 010", c, {busy, sram_we_n, host_ack});
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        zx_rnw = 1'b0; zx_page = 3'b001; zx_addr = 16'hBEEF; zx_wdata = 8'h77;
        zx_req = 1'b1;
        tick(); tick();
        total++;
        if (sram_we_n !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_access: we_n=%b expected 0", sram_we_n);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({sram_we_n, sram_oe_n, sram_dir, busy, zx_stb} !== 5'b11000) begin
            bad++;
            $display("FAIL rst_mid_abort: we,oe,dir,busy,stb=%b expected 11000", {sram_we_n, sram_oe_n, sram_dir, busy, zx_stb});
        end
        zx_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({zx_stb, busy} !== 2'b00) begin
                bad++;
                $display("FAIL rst_mid_quiet: stb=%b busy=%b expected 0 0", zx_stb, busy);
            end
        end
        zx_rnw = 1'b1; zx_page = 3'b110; zx_addr = 16'h4321;
        sb.push_back('{is_host: 1'b0, rnw: 1'b1, addr: 19'h64321, data: 8'hB0});
        zx_req = 1'b1;
        wait_zx(lat);
        total++;
        if ({lat, zx_rdata} !== {WS + 2, 8'hB0}) begin
            bad++;
            $display("FAIL rst_fresh: latency=%0d rdata=%h expected %0d b0", lat, zx_rdata, WS + 2);
        end
        zx_req = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_zx_read();
        tick();
        test_host_write();
        tick();
        test_simultaneous();
        test_starvation();
        test_host_hold();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d expected transactions never completed", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
